// File: rtl/fifo_queue_pkg.sv
// Shared defaults for the FIFO queue slice: data width, depth and a
// clog2-style helper used to derive the pointer width from the depth.
package fifo_queue_pkg;

    localparam int DEF_W     = 4;
    localparam int DEF_DEPTH = 8;

    // Smallest n with 2**n >= depth; depth is a power of two, so this is exact.
    function automatic int aw_of(input int depth);
        int n;
        n = 0;
        while ((1 << n) < depth) n++;
        return n;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Turns a held button level into a one-cycle request pulse on each 0->1
// transition. Inputs are assumed already debounced/synchronised upstream.
module edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic level,
    output logic pulse
);

    logic prev;

    // Remember last cycle's level so a held button only counts once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prev <= 1'b0;
        else       prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/fifo_queue.sv
// Circular FIFO of DEPTH words x W bits. `head` shows the current front
// entry, `out` holds the last dequeued word. full/empty decode the count.
// Optional feature: FIFO_QUEUE_EDGE_DETECT_EN treats enq/deq as button
// levels and issues one request per rising transition.
module fifo_queue
    import fifo_queue_pkg::*;
#(
    parameter  int W     = DEF_W,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = aw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enq,
    input  logic [W-1:0]  in,
    input  logic          deq,
    output logic [W-1:0]  out,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic          enq_s, deq_s;
    logic          enq_ok, deq_ok;
    logic [AW-1:0] wp, rp;
    logic [W-1:0]  mem [DEPTH];

`ifdef FIFO_QUEUE_EDGE_DETECT_EN
    edge_detect u_enq_ed (.clk(clk), .rstn(rstn), .level(enq), .pulse(enq_s));
    edge_detect u_deq_ed (.clk(clk), .rstn(rstn), .level(deq), .pulse(deq_s));
`else
    assign enq_s = enq;
    assign deq_s = deq;
`endif

    // A full queue still takes a write when a read frees the slot this edge;
    // an empty queue never reads, so there is no write-through bypass.
    assign deq_ok = deq_s & ~empty;
    assign enq_ok = enq_s & (~full | deq_ok);

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rp];

    // Storage is not reset; stale words are never visible because head is
    // only meaningful while non-empty and out only loads on accepted reads.
    always_ff @(posedge clk) begin
        if (enq_ok) mem[wp] <= in;
    end

    // Pointers, occupancy and the output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            out   <= '0;
        end else begin
            if (enq_ok) wp <= wp + 1'b1;
            if (deq_ok) begin
                rp  <= rp + 1'b1;
                out <= mem[rp];
            end
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_queue.sv
// Self-checking bench for fifo_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_fifo_queue;

    localparam int W     = 4;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         enq = 1'b0;
    logic         deq = 1'b0;
    logic [W-1:0] in = '0;
    logic [W-1:0] out;
    logic [W-1:0] head;
    logic         full;
    logic         empty;
    logic [3:0]   count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] out_m = '0;
    logic         pe = 1'b0, pd = 1'b0;

`ifdef FIFO_QUEUE_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    fifo_queue dut (
        .clk(clk), .rstn(rstn), .enq(enq), .in(in), .deq(deq),
        .out(out), .head(head), .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, "_full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, "_out"},   32'(out),   32'(out_m));
        if (q.size() > 0) chk({tag, "_head"}, 32'(head), 32'(q[0]));
    endtask

    // One clock with the given levels; model follows the acceptance rules.
    task automatic cycle(input logic e, input logic d, input logic [W-1:0] data, input string tag);
        logic ee, dd, dok, eok;
        enq = e; deq = d; in = data;
        ee = EDGE ? (e & ~pe) : e;
        dd = EDGE ? (d & ~pd) : d;
        pe = e; pd = d;
        dok = dd && (q.size() > 0);
        eok = ee && ((q.size() < DEPTH) || dok);
        @(posedge clk);
        if (dok) out_m = q.pop_front();
        if (eok) q.push_back(data);
        @(negedge clk);
        chk_all(tag);
    endtask

    // One logical request; in edge mode the level is released afterwards
    // so back-to-back steps are separate requests.
    task automatic step(input logic e, input logic d, input logic [W-1:0] data, input string tag);
        cycle(e, d, data, tag);
        if (EDGE) cycle(1'b0, 1'b0, '0, tag);
    endtask

    task automatic do_reset(input string tag);
        enq = 1'b0; deq = 1'b0;
        #2 rstn = 1'b0;
        #1;
        q.delete(); out_m = '0; pe = 1'b0; pd = 1'b0;
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full),  32'd0);
        chk({tag, "_out"},   32'(out),   32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_out",   32'(out),   32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: three enqueues
        step(1, 0, 4'h1, "t1"); step(1, 0, 4'h2, "t1"); step(1, 0, 4'h3, "t1");
        chk("t1_count3", 32'(count), 32'd3);
        chk("t1_head1",  32'(head),  32'h1);
        do_reset("t1_rst");

        // 2: fill, overflow dropped, drain in order
        for (int i = 0; i < 8; i++) step(1, 0, 4'(i), "t2_fill");
        step(1, 0, 4'hF, "t2_ovf");
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count8", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, '0, "t2_drain");
            chk("t2_outseq", 32'(out), 32'(i));
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: pointer wrap
        for (int i = 0; i < 8; i++) step(1, 0, 4'(i), "t3_fill");
        for (int i = 0; i < 5; i++) step(0, 1, '0, "t3_deq");
        for (int i = 0; i < 5; i++) step(1, 0, 4'(4'hA + i), "t3_enq");
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] exp_t3;
            exp_t3 = (i < 3) ? 4'(5 + i) : 4'(4'hA + i - 3);
            step(0, 1, '0, "t3_drain");
            chk("t3_outseq", 32'(out), 32'(exp_t3));
        end

        // 4: full + both, then empty + both
        for (int i = 0; i < 8; i++) step(1, 0, 4'(i + 1), "t4_fill");
        step(1, 1, 4'h9, "t4_both_full");
        chk("t4_out_old_head", 32'(out), 32'h1);
        chk("t4_count8", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) step(0, 1, '0, "t4_drain");
        chk("t4_last9", 32'(out), 32'h9);
        step(1, 1, 4'h6, "t4_both_empty");
        chk("t4_count1", 32'(count), 32'd1);
        chk("t4_out_hold", 32'(out), 32'h9);
        step(0, 1, '0, "t4_pop");

        // 5: dequeue while empty, then reset mid-burst
        step(0, 1, '0, "t5_deq_empty");
        chk("t5_out_hold", 32'(out), 32'h6);
        chk("t5_count0", 32'(count), 32'd0);
        step(1, 0, 4'h4, "t5_ptr");
        chk("t5_head4", 32'(head), 32'h4);
        for (int i = 0; i < 4; i++) step(1, 0, 4'(i + 8), "t5_burst");
        do_reset("t5_rst");
        step(1, 0, 4'hC, "t5_after");
        chk("t5_after_head", 32'(head), 32'hC);

        // 6: hold enq high for 10 cycles from empty
        do_reset("t6_rst");
        for (int i = 0; i < 10; i++) cycle(1, 0, 4'(i), "t6_hold");
        chk("t6_count", 32'(count), EDGE ? 32'd1 : 32'd8);
        chk("t6_full",  32'(full),  EDGE ? 32'd0 : 32'd1);
        cycle(0, 0, '0, "t6_rel");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rnd_rst");
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
